fp_add2: RTL and testbench
==========================

# fp_add2

Pipelined IEEE-754-style floating-point adder with parameterised exponent and mantissa widths. The default is binary16: 1 sign, 5 exponent and 10 mantissa bits. It is the accumulation primitive in the CNN datapath, summing products and partial sums. It accepts one operand pair per clock and returns the packed sum split into sign, exponent and mantissa fields.

## Interface
Parameters:
- EXPONENT_WIDTH, 5, exponent field width; bias = 2^(EXPONENT_WIDTH-1)-1.
- MANTISSA_WIDTH, 10, stored fraction width; the hidden bit is not stored.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- A_FP  in  EXPONENT_WIDTH+MANTISSA_WIDTH+1  operand A, packed {sign, exponent, mantissa}.
- B_FP  in  EXPONENT_WIDTH+MANTISSA_WIDTH+1  operand B, same format.
- sign  out  1  result sign.
- exponent  out  EXPONENT_WIDTH  biased result exponent.
- mantissa  out  MANTISSA_WIDTH  result fraction.

## Operation
- Unpack operands:
  - Exponent field 0 means zero. Subnormal inputs are flushed to zero and the sign is kept.
  - Exponent field all-ones means Inf if the mantissa is 0, NaN otherwise.
- Order operands by magnitude (exponent, then mantissa), giving large L and small S.
- Result sign is sign(L).
- Align S:
  - Right-shift by the exponent difference.
  - Keep guard and round bits plus a sticky bit (OR of all bits shifted out).
  - A shift ≥ MANTISSA_WIDTH+3 leaves only sticky.
- Add the significands if the signs match; otherwise subtract (L−S, never negative).
- Normalise:
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise left-shift by the leading-zero count and decrement the exponent.
- Round to nearest, ties to even, using guard/round/sticky. A rounding carry renormalises.
- Special cases:
  - Exact zero result, including x + (−x), gives +0 (all fields 0).
  - Underflow (exponent ≤ 0 after normalisation) flushes to signed zero.
  - Overflow (exponent ≥ all-ones) gives Inf of the result sign (exponent all-ones, mantissa 0).
  - Any NaN input, or +Inf + −Inf, gives the quiet NaN: sign 0, exponent all-ones, mantissa MSB 1, rest 0.
  - Inf + finite gives that Inf.
  - 0 + x gives x. (−0) + (−0) gives −0.

## Timing
- Two-stage pipeline; throughput is one operation per cycle with no stall and no handshake.
- Stage 1, registered on rising edge k: unpack, classify, swap, align, add/subtract.
- Stage 2, registered on edge k+1: normalise, round, pack into output registers.
- Operands present before edge k appear on sign/exponent/mantissa after edge k+1, a latency of 2 edges.
- Back-to-back inputs produce back-to-back results in order.
- rst_n low:
  - Immediately clears all pipeline registers and outputs (sign=0, exponent=0, mantissa=0), independent of clk.
  - Outputs stay 0 until the second rising edge after rst_n deasserts.
  - An operation in flight when reset asserts is discarded.
- Outputs are driven only from registers, never combinationally from the inputs.

## Structure
- Shared package fp_pkg holds:
  - the default widths;
  - the bias function;
  - constants EXP_ALL_ONES and QNAN_MANT;
  - a classification enum: ZERO, NORMAL, INF, NAN.
- One sub-module, fp_lzc: a parameterised leading-zero counter on the (MANTISSA_WIDTH+4)-bit sum used by normalisation.
- Everything else lives in fp_add2.

## Test plan
Binary16 defaults; each result is checked 2 edges after the inputs are applied.
- 7.25 + 0.375: A=0x4740, B=0x3600 → 7.625 = 0x47A0 (sign 0, exponent 10001, mantissa 1110100000).
- Same-sign carry-out:
  - 6 + 7: 0x4600 + 0x4700 → 13 = 0x4A80.
  - −7 + −3: 0xC700 + 0xC200 → −10 = 0xC900.
- Mixed signs:
  - 7 + −3: 0x4700 + 0xC200 → 4 = 0x4400.
  - −7 + 3: 0xC700 + 0x4200 → −4 = 0xC400.
  - 65 − 63: 0x5410 + 0xD3E0 → 2 = 0x4000 (5-position left normalisation).
- Cancellation, equal operands and rounding:
  - 4 + −4: 0x4400 + 0xC400 → 0x0000.
  - 4 + 4: 0x4400 + 0x4400 → 8 = 0x4800.
  - 1 + 2^−11: 0x3C00 + 0x1000 → 0x3C00 (tie rounds to even).
- Specials, each with a pipelined stream of all of the above on consecutive cycles:
  - 0x7BFF + 0x7BFF → +Inf 0x7C00.
  - 0x7C00 + 0xFC00 → 0x7E00.
  - NaN input → 0x7E00.
  - Assert rst_n mid-stream → outputs read 0 immediately; the stream resumes correctly after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point datapath: default binary16 widths,
// exponent bias helper, special-value constants and operand classification.
package fp_pkg;

   localparam int DEF_EXP_WIDTH  = 5;
   localparam int DEF_MANT_WIDTH = 10;

   localparam logic [DEF_EXP_WIDTH-1:0]  EXP_ALL_ONES = '1;
   localparam logic [DEF_MANT_WIDTH-1:0] QNAN_MANT    = {1'b1, {(DEF_MANT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ZERO,
      NORMAL,
      INF,
      NAN
   } fp_class_e;

   function automatic int expBias(input int expWidth);
      return (1 << (expWidth - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter int WIDTH       = 14,
   parameter int COUNT_WIDTH = 4
) (
   input  logic [WIDTH-1:0]       i_data,
   output logic [COUNT_WIDTH-1:0] o_count
);

   // Scanning upward lets the most significant set bit win.
   always_comb begin
      o_count = COUNT_WIDTH'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (i_data[i]) begin
            o_count = COUNT_WIDTH'(WIDTH - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fp_add2.sv
// Two-stage pipelined floating-point adder: stage 1 classifies, orders, aligns
// and adds; stage 2 normalises, rounds to nearest-even and packs the result.
module fp_add2
   import fp_pkg::*;
#(
   parameter int EXPONENT_WIDTH = DEF_EXP_WIDTH,
   parameter int MANTISSA_WIDTH = DEF_MANT_WIDTH
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   A_FP,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   B_FP,
   output logic                                     sign,
   output logic [EXPONENT_WIDTH-1:0]                exponent,
   output logic [MANTISSA_WIDTH-1:0]                mantissa
);

   localparam int EW  = EXPONENT_WIDTH;
   localparam int MW  = MANTISSA_WIDTH;
   localparam int W   = EW + MW + 1;
   localparam int AW  = MW + 3;
   localparam int SW  = MW + 4;
   localparam int CW  = $clog2(SW + 1);
   localparam int EXW = EW + 2;

   localparam logic [EW-1:0]         EXP_ONES = '1;
   localparam logic [MW-1:0]         QNAN     = {1'b1, {(MW-1){1'b0}}};
   localparam logic signed [EXW-1:0] ONE_S    = 1;
   localparam logic signed [EXW-1:0] ZERO_S   = 0;
   localparam logic signed [EXW-1:0] ONES_S   = {2'b00, EXP_ONES};

   logic            w_sA, w_sB, w_sL, w_sub, w_zeroS, w_aIsLarge;
   logic [EW-1:0]   w_eA, w_eB, w_eL, w_eS, w_expDiff;
   logic [MW-1:0]   w_mA, w_mB, w_mL, w_mS;
   fp_class_e       w_clsA, w_clsB;
   logic [EW+MW-1:0] w_keyA, w_keyB;
   int              w_shiftAmt;
   logic [AW-1:0]   w_sigS;
   logic [2*AW-1:0] w_shifted;
   logic [SW-1:0]   w_largeExt, w_smallAligned;
   logic [SW:0]     w_sum;
   logic            w_special;
   logic [W-1:0]    w_specRes;

   logic            r_s1Special, r_s1Sign;
   logic [W-1:0]    r_s1SpecRes;
   logic [EW-1:0]   r_s1Exp;
   logic [SW:0]     r_s1Sum;

   logic            r_sign;
   logic [EW-1:0]   r_exponent;
   logic [MW-1:0]   r_mantissa;

   assign w_sA = A_FP[W-1];
   assign w_eA = A_FP[W-2:MW];
   assign w_mA = A_FP[MW-1:0];
   assign w_sB = B_FP[W-1];
   assign w_eB = B_FP[W-2:MW];
   assign w_mB = B_FP[MW-1:0];

   // Subnormals fall into ZERO here, which is what flushes them.
   always_comb begin
      w_clsA = NORMAL;
      w_clsB = NORMAL;
      if (w_eA == '0)            w_clsA = ZERO;
      else if (w_eA == EXP_ONES) w_clsA = (w_mA == '0) ? INF : NAN;
      if (w_eB == '0)            w_clsB = ZERO;
      else if (w_eB == EXP_ONES) w_clsB = (w_mB == '0) ? INF : NAN;
   end

   assign w_keyA     = (w_clsA == ZERO) ? '0 : {w_eA, w_mA};
   assign w_keyB     = (w_clsB == ZERO) ? '0 : {w_eB, w_mB};
   assign w_aIsLarge = (w_keyA >= w_keyB);
   assign w_sub      = w_sA ^ w_sB;

   always_comb begin
      w_sL    = w_sB;
      w_eL    = w_eB;
      w_mL    = w_mB;
      w_eS    = w_eA;
      w_mS    = w_mA;
      w_zeroS = (w_clsA == ZERO);
      if (w_aIsLarge) begin
         w_sL    = w_sA;
         w_eL    = w_eA;
         w_mL    = w_mA;
         w_eS    = w_eB;
         w_mS    = w_mB;
         w_zeroS = (w_clsB == ZERO);
      end
   end

   // The lower half of the shift window collects everything pushed past the
   // round bit, so a clamp at AW still folds the whole operand into sticky.
   assign w_expDiff      = w_eL - w_eS;
   assign w_shiftAmt     = (int'(w_expDiff) >= AW) ? AW : int'(w_expDiff);
   assign w_sigS         = w_zeroS ? '0 : {1'b1, w_mS, 2'b00};
   assign w_shifted      = {w_sigS, {AW{1'b0}}} >> w_shiftAmt;
   assign w_smallAligned = {w_shifted[2*AW-1:AW], |w_shifted[AW-1:0]};
   assign w_largeExt     = {1'b1, w_mL, 3'b000};
   assign w_sum          = w_sub ? ({1'b0, w_largeExt} - {1'b0, w_smallAligned})
                                 : ({1'b0, w_largeExt} + {1'b0, w_smallAligned});

   always_comb begin
      w_special = 1'b0;
      w_specRes = '0;
      if ((w_clsA == NAN) || (w_clsB == NAN) ||
          ((w_clsA == INF) && (w_clsB == INF) && w_sub)) begin
         w_special = 1'b1;
         w_specRes = {1'b0, EXP_ONES, QNAN};
      end else if (w_clsA == INF) begin
         w_special = 1'b1;
         w_specRes = A_FP;
      end else if (w_clsB == INF) begin
         w_special = 1'b1;
         w_specRes = B_FP;
      end else if ((w_clsA == ZERO) && (w_clsB == ZERO)) begin
         w_special = 1'b1;
         w_specRes = {w_sA & w_sB, {(W-1){1'b0}}};
      end
   end

   // Stage 1 register: aligned sum plus any special-case result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Special <= 1'b0;
         r_s1SpecRes <= '0;
         r_s1Sign    <= 1'b0;
         r_s1Exp     <= '0;
         r_s1Sum     <= '0;
      end else begin
         r_s1Special <= w_special;
         r_s1SpecRes <= w_specRes;
         r_s1Sign    <= w_sL;
         r_s1Exp     <= w_eL;
         r_s1Sum     <= w_sum;
      end
   end

   logic [CW-1:0]         w_lz;
   logic [SW-1:0]         w_norm;
   logic signed [EXW-1:0] w_expBase, w_expNorm, w_expFinal;
   logic                  w_roundUp;
   logic [MW+1:0]         w_mantR;
   logic [MW-1:0]         w_mantFinal;
   logic [W-1:0]          w_result;

   fp_lzc #(
      .WIDTH       (SW),
      .COUNT_WIDTH (CW)
   ) u_lzc (
      .i_data  (r_s1Sum[SW-1:0]),
      .o_count (w_lz)
   );

   assign w_expBase = {2'b00, r_s1Exp};

   // A carry-out keeps the dropped bit alive by folding it into sticky.
   always_comb begin
      if (r_s1Sum[SW]) begin
         w_norm    = {r_s1Sum[SW:2], r_s1Sum[1] | r_s1Sum[0]};
         w_expNorm = w_expBase + ONE_S;
      end else begin
         w_norm    = r_s1Sum[SW-1:0] << w_lz;
         w_expNorm = w_expBase - EXW'(w_lz);
      end
   end

   assign w_roundUp   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
   assign w_mantR     = {1'b0, w_norm[SW-1:3]} + {{(MW+1){1'b0}}, w_roundUp};
   assign w_expFinal  = w_expNorm + (w_mantR[MW+1] ? ONE_S : ZERO_S);
   assign w_mantFinal = w_mantR[MW+1] ? w_mantR[MW:1] : w_mantR[MW-1:0];

   always_comb begin
      w_result = {r_s1Sign, w_expFinal[EW-1:0], w_mantFinal};
      if (r_s1Special)                w_result = r_s1SpecRes;
      else if (r_s1Sum == '0)         w_result = '0;
      else if (w_expNorm <= ZERO_S)   w_result = {r_s1Sign, {(W-1){1'b0}}};
      else if (w_expFinal >= ONES_S)  w_result = {r_s1Sign, EXP_ONES, {MW{1'b0}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign     <= 1'b0;
         r_exponent <= '0;
         r_mantissa <= '0;
      end else begin
         r_sign     <= w_result[W-1];
         r_exponent <= w_result[W-2:MW];
         r_mantissa <= w_result[MW-1:0];
      end
   end

   assign sign     = r_sign;
   assign exponent = r_exponent;
   assign mantissa = r_mantissa;

endmodule

// File: tb/tb_fp_add2.sv
// Scoreboard bench for fp_add2 (binary16): directed vectors plus random
// operands checked against an exact-arithmetic reference model.
module tb_fp_add2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] aFp = '0;
   logic [15:0] bFp = '0;
   logic        sign;
   logic [4:0]  exponent;
   logic [9:0]  mantissa;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] expected;
   } item_t;

   item_t       scoreQ[$];
   int          errors = 0;
   int          checks = 0;
   logic        issued = 1'b0;
   logic [1:0]  vPipe;

   fp_add2 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .A_FP     (aFp),
      .B_FP     (bFp),
      .sign     (sign),
      .exponent (exponent),
      .mantissa (mantissa)
   );

   always #5 clk = ~clk;

   // Marks which output cycles carry a result issued two edges earlier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vPipe <= '0;
      else        vPipe <= {vPipe[0], issued};
   end

   // Exact sum of the two decoded values, rounded to nearest-even with
   // flush-to-zero below the normal range.
   function automatic logic [15:0] refAdd(input logic [15:0] a, input logic [15:0] b);
      int     eA, eB, mA, mB, p, sh, eRes;
      logic   sA, sB, sgn;
      longint va, vb, sum, mag, q, rem, half;
      eA = int'(a[14:10]); mA = int'(a[9:0]); sA = a[15];
      eB = int'(b[14:10]); mB = int'(b[9:0]); sB = b[15];
      if ((eA == 31 && mA != 0) || (eB == 31 && mB != 0)) return 16'h7E00;
      if (eA == 31 && eB == 31 && sA != sB) return 16'h7E00;
      if (eA == 31) return a;
      if (eB == 31) return b;
      if (eA == 0 && eB == 0) return {sA & sB, 15'h0};
      va = (eA == 0) ? 0 : (longint'(1024 + mA) << (eA - 1));
      vb = (eB == 0) ? 0 : (longint'(1024 + mB) << (eB - 1));
      if (sA) va = -va;
      if (sB) vb = -vb;
      sum = va + vb;
      if (sum == 0) return 16'h0000;
      sgn = (sum < 0);
      mag = sgn ? -sum : sum;
      p = 0;
      for (int i = 0; i < 63; i++) if (mag[i]) p = i;
      eRes = p - 9;
      if (eRes <= 0) return {sgn, 15'h0};
      sh = p - 10;
      q  = mag >> sh;
      if (sh > 0) begin
         rem  = mag - (q << sh);
         half = longint'(1) << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
      end
      if (q == 2048) begin
         q = 1024;
         eRes = eRes + 1;
      end
      if (eRes >= 31) return {sgn, 5'h1F, 10'h0};
      return {sgn, 5'(eRes), 10'(q)};
   endfunction

   function automatic logic [15:0] randNormal();
      return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] expected);
      logic [15:0] got;
      got = {sign, exponent, mantissa};
      checks++;
      if (got !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] expected);
      item_t it;
      aFp = a;
      bFp = b;
      issued = 1'b1;
      it.a = a;
      it.b = b;
      it.expected = expected;
      scoreQ.push_back(it);
      @(negedge clk);
   endtask

   task automatic applyRandom();
      logic [15:0] a, b;
      int e;
      a = randNormal();
      case ($urandom_range(0, 3))
         0: begin
            a = 16'($urandom);
            b = 16'($urandom);
         end
         1: begin
            e = int'(a[14:10]) + int'($urandom_range(0, 6)) - 3;
            if (e < 1) e = 1;
            if (e > 30) e = 30;
            b = {1'($urandom), 5'(e), 10'($urandom)};
         end
         2: b = (a ^ 16'h8000) ^ 16'($urandom_range(0, 7));
         default: begin
            e = int'(a[14:10]) - int'($urandom_range(10, 16));
            if (e < 1) e = 1;
            b = {1'($urandom), 5'(e), 10'($urandom)};
         end
      endcase
      applyStimulus(a, b, refAdd(a, b));
   endtask

   // Monitor: pops the oldest expectation whenever a result is due.
   always @(negedge clk) begin
      item_t it;
      if (rst_n && vPipe[1]) begin
         if (scoreQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard-empty: got %h expected none",
                     {sign, exponent, mantissa});
         end else begin
            it = scoreQ.pop_front();
            checkOutput($sformatf("sum %h+%h", it.a, it.b), it.expected);
         end
      end
   end

   logic [15:0] dirA [16] = '{16'h4740, 16'h4600, 16'hC700, 16'h4700, 16'hC700, 16'h5410,
                              16'h4400, 16'h4400, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h7C01,
                              16'h8000, 16'h0000, 16'h7C00, 16'h0200};
   logic [15:0] dirB [16] = '{16'h3600, 16'h4700, 16'hC200, 16'hC200, 16'h4200, 16'hD3E0,
                              16'hC400, 16'h4400, 16'h1000, 16'h7BFF, 16'hFC00, 16'h3C00,
                              16'h8000, 16'h4740, 16'h4400, 16'hC740};
   logic [15:0] dirE [16] = '{16'h47A0, 16'h4A80, 16'hC900, 16'h4400, 16'hC400, 16'h4000,
                              16'h0000, 16'h4800, 16'h3C00, 16'h7C00, 16'h7E00, 16'h7E00,
                              16'h8000, 16'h4740, 16'h7C00, 16'hC740};

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset-state", 16'h0000);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) applyStimulus(dirA[i], dirB[i], dirE[i]);
      for (int i = 0; i < 200; i++) applyRandom();

      #2 rst_n = 1'b0;
      #1 checkOutput("async-reset", 16'h0000);
      scoreQ.delete();
      issued = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(dirA[0], dirB[0], dirE[0]);
      checkOutput("post-release-hold", 16'h0000);
      for (int i = 1; i < 16; i++) applyStimulus(dirA[i], dirB[i], dirE[i]);
      for (int i = 0; i < 200; i++) applyRandom();

      issued = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (scoreQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", scoreQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
